pr_write_buffer: RTL and testbench
==================================

# pr_write_buffer

Parametrised posted-write buffer with a wait-state handshake, placed between the CPU's MEM-stage processor bus (word address, write data, byte enables, write strobe, read data) and the system bridge/devices. Stores are queued and retired to slow devices in order, without stalling the pipeline. Reads drain the queue first, then complete through a device ready handshake. A `stall` output feeds the pipeline stall detector.

## Interface
- `DEPTH`, 4, entries in the write queue; power of two, ≥2
- `AW`, 30, word-address width (byte address bits [31:2])
- `DW`, 32, data width; byte-enable width is DW/8
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cpu_addr`  in  AW  word address from MEM stage
- `cpu_wd`  in  DW  store data
- `cpu_be`  in  DW/8  store byte enables
- `cpu_we`  in  1  store request
- `cpu_re`  in  1  load request
- `cpu_rd`  out  DW  load data (registered)
- `stall`  out  1  hold MEM stage and everything upstream
- `dev_addr`  out  AW  device word address
- `dev_wd`  out  DW  device write data
- `dev_be`  out  DW/8  device byte enables
- `dev_we`  out  1  device write strobe
- `dev_re`  out  1  device read strobe
- `dev_rd`  in  DW  device read data
- `dev_ready`  in  1  device completes current access this cycle
- `count`  out  log2(DEPTH)+1  entries currently queued

## Operation
- Queue: circular buffer of {addr, wd, be}. Head/tail pointers are log2(DEPTH)+1 bits; the extra wrap bit separates full from empty. `count` = tail − head.
- Enqueue: `cpu_we` && !full → write at tail, tail+1. When full, `stall`=1 and nothing is enqueued. The CPU holds the request. Full is evaluated on registered state, so a same-cycle pop does not lift the stall.
- `cpu_we` && `cpu_re` together is treated as a write only; the read is ignored.
- Device FSM states: IDLE, WRITE, READ, RDONE.
  - IDLE: if count>0 → WRITE. Else if `cpu_re` → READ.
  - WRITE: `dev_we`=1; `dev_addr`/`dev_wd`/`dev_be` = head entry. On `dev_ready`: pop (head+1). If count after pop >0, stay in WRITE; else go to IDLE.
  - READ: `dev_re`=1, `dev_addr`=`cpu_addr`. On `dev_ready`: `cpu_rd`←`dev_rd`, go to RDONE.
  - RDONE: one cycle, then IDLE.
- `stall` = (`cpu_we` && !`cpu_re`-only && full) || (`cpu_re` && !`cpu_we` && state≠RDONE). `stall` is forced to 0 while `rst` is high.
- Ordering: a read issues only after every earlier write has retired (count=0). Reads are never forwarded from the queue.
- Outputs not being driven (dev_addr/wd/be outside WRITE/READ) are 0.
- Reset: head=tail=0, state IDLE, `cpu_rd`=0, `dev_we`=`dev_re`=0, `count`=0. Pending writes are discarded. Outputs go to these values asynchronously on `rst` assertion.

## Timing
- Write accepted at edge N → earliest `dev_we` in cycle N+1.
- With `dev_ready` held high, throughput is one retired write per cycle. Enqueue and pop in the same cycle leave count unchanged.
- Read with an empty queue and `dev_ready`=1:
  - cycle N: `cpu_re`, `stall`=1
  - cycle N+1: READ, `dev_re`=1
  - cycle N+2: RDONE, `stall`=0, `cpu_rd` valid
  - Minimum 2 stall cycles.
- Each low cycle of `dev_ready` adds one cycle. Device-side signals stay stable until `dev_ready`.
- `cpu_re` still high in the cycle after RDONE is a new read.

## Test plan
- Reset: assert `rst` mid-run with count=3 and `dev_we`=1 → `count`=0, `dev_we`=`dev_re`=0, `cpu_rd`=0 before the next edge. A write issued after release retires normally.
- Fill: DEPTH=4, `dev_ready`=0, writes to 0x100..0x104 back-to-back → first four accepted with `stall`=0 and count=4. Fifth write sees `stall`=1. Raise `dev_ready` → 0x100..0x104 appear on `dev_addr` in order, one per cycle. The fifth write is accepted the cycle after the first pop.
- Wait states: one write of 0xA5A5A5A5, be=0011, `dev_ready` low for 3 cycles → `dev_we`, `dev_addr`, `dev_wd`, `dev_be` stable for 4 cycles; count drops to 0 only after `dev_ready`.
- Read after writes: two writes queued, then `cpu_re` at 0x200, `dev_rd`=0xDEADBEEF, `dev_ready`=1 → both writes retire before `dev_re`. `cpu_rd`=0xDEADBEEF with `stall` low in RDONE.
- Wrap-around: 10 writes through DEPTH=4 with pseudo-random `dev_ready` → device sees all 10 addr/data/be exactly in order. count never exceeds 4.
- Simultaneous `cpu_we`+`cpu_re` → treated as a write: enqueued, `dev_re` never asserted.

Source files
------------

// File: rtl/pr_write_buffer_if.sv
// Processor-bus / device-bus bundle for the posted-write buffer.
// slave is the buffer's view; master is the CPU+device environment view.
interface pr_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wd;
  logic [DW/8-1:0] cpu_be;
  logic            cpu_we;
  logic            cpu_re;
  logic [DW-1:0]   cpu_rd;
  logic            stall;

  logic [AW-1:0]   dev_addr;
  logic [DW-1:0]   dev_wd;
  logic [DW/8-1:0] dev_be;
  logic            dev_we;
  logic            dev_re;
  logic [DW-1:0]   dev_rd;
  logic            dev_ready;

  logic [CW-1:0]   count;

  modport slave (
    input  cpu_addr, cpu_wd, cpu_be, cpu_we, cpu_re, dev_rd, dev_ready,
    output cpu_rd, stall, dev_addr, dev_wd, dev_be, dev_we, dev_re, count
  );

  modport master (
    output cpu_addr, cpu_wd, cpu_be, cpu_we, cpu_re, dev_rd, dev_ready,
    input  cpu_rd, stall, dev_addr, dev_wd, dev_be, dev_we, dev_re, count
  );
endinterface

// File: rtl/pr_write_buffer.sv
// Posted-write buffer: stores enqueue in 1 cycle and retire in order; reads drain the queue, then take >=2 cycles.
// Backpressure: stall on store when full (registered), and on load until its data is returned; device waits via dev_ready.
module pr_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             rst,
  pr_write_buffer_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

  entry_t        mem [DEPTH];
  logic [CW-1:0] head;
  logic [CW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic [PW-1:0] head_idx;
  logic [PW-1:0] head_nxt_idx;
  state_t        state;

  entry_t        dev_q;
  logic          dev_we_q;
  logic          dev_re_q;
  logic [DW-1:0] cpu_rd_q;

  entry_t        cpu_entry;
  entry_t        next_entry;
  logic          full;
  logic          rd_only;
  logic          push;
  logic          pop;

  assign count        = tail - head;
  assign full         = (count == CW'(DEPTH));
  assign rd_only      = bus.cpu_re && !bus.cpu_we;
  assign push         = bus.cpu_we && !full;
  assign pop          = (state == WRITE) && bus.dev_ready;
  assign count_after  = count - {{(CW-1){1'b0}}, pop} + {{(CW-1){1'b0}}, push};
  assign head_idx     = head[PW-1:0];
  assign head_nxt_idx = head_idx + PW'(1);
  assign cpu_entry    = '{addr: bus.cpu_addr, wd: bus.cpu_wd, be: bus.cpu_be};

  // Entry to present on the device bus next cycle. An empty queue (IDLE) or a
  // single entry being popped (WRITE) means the only candidate is the store
  // being enqueued this very edge, so bypass it around the array.
  always_comb begin
    next_entry = mem[head_nxt_idx];
    if (state == IDLE) begin
      next_entry = (count == '0) ? cpu_entry : mem[head_idx];
    end else if (count == CW'(1)) begin
      next_entry = cpu_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail[PW-1:0]] <= cpu_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      state    <= IDLE;
      dev_q    <= '0;
      dev_we_q <= 1'b0;
      dev_re_q <= 1'b0;
      cpu_rd_q <= '0;
    end else begin
      if (push) begin
        tail <= tail + CW'(1);
      end
      if (pop) begin
        head <= head + CW'(1);
      end

      case (state)
        IDLE: begin
          if (count != '0 || push) begin
            state    <= WRITE;
            dev_we_q <= 1'b1;
            dev_q    <= next_entry;
          end else if (rd_only) begin
            state    <= READ;
            dev_re_q <= 1'b1;
            dev_q    <= '{addr: bus.cpu_addr, default: '0};
          end
        end
        WRITE: begin
          if (bus.dev_ready) begin
            if (count_after != '0) begin
              dev_q <= next_entry;
            end else begin
              state    <= IDLE;
              dev_we_q <= 1'b0;
              dev_q    <= '0;
            end
          end
        end
        READ: begin
          if (bus.dev_ready) begin
            state    <= RDONE;
            cpu_rd_q <= bus.dev_rd;
            dev_re_q <= 1'b0;
            dev_q    <= '0;
          end
        end
        RDONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Full uses registered occupancy only, so a pop in the same cycle keeps the stall.
  assign bus.stall    = !rst && ((bus.cpu_we && full) || (rd_only && state != RDONE));
  assign bus.cpu_rd   = cpu_rd_q;
  assign bus.dev_addr = dev_q.addr;
  assign bus.dev_wd   = dev_q.wd;
  assign bus.dev_be   = dev_q.be;
  assign bus.dev_we   = dev_we_q;
  assign bus.dev_re   = dev_re_q;
  assign bus.count    = count;
endmodule

// File: tb/tb_pr_write_buffer.sv
// Directed bench for pr_write_buffer with a device-write scoreboard.
module tb_pr_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam int DW    = 32;

  logic clk;
  logic rst;

  pr_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  pr_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int max_count = 0;
  bit re_seen = 0;
  logic [65:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Device-side monitor: every retired write must be the oldest expected store.
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(bus.count) > max_count) max_count = int'(bus.count);
      if (bus.dev_re) re_seen = 1'b1;
      if (bus.dev_we && bus.dev_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", {bus.dev_addr, bus.dev_wd, bus.dev_be}, 128'h0);
        end else begin
          check("sb_write", {bus.dev_addr, bus.dev_wd, bus.dev_be}, exp_q.pop_front());
        end
      end
      if (bus.dev_re && bus.dev_ready) begin
        check("rd_after_writes", exp_q.size(), 0);
      end
    end
  end

  task automatic do_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b, input bit rnd);
    int n;
    n = 0;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_wd   = d;
    bus.cpu_be   = b;
    while (n < 60) begin
      if (rnd) bus.dev_ready = 1'($urandom_range(0, 1));
      #1;
      if (!bus.stall) begin
        exp_q.push_back({a, d, b});
        tick();
        break;
      end
      tick();
      n++;
    end
    check("wr_accept_timeout", n < 60, 1);
    bus.cpu_we = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((bus.count != '0 || bus.dev_we) && n < 100) begin
      if (rnd) bus.dev_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("drain_timeout", n < 100, 1);
    bus.dev_ready = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wd = '0; bus.cpu_be = '0;
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
    bus.dev_rd = '0; bus.dev_ready = 1'b0;
    tick(); tick();
    check("reset_state", {bus.count, bus.dev_we, bus.dev_re, bus.cpu_rd, bus.stall}, 0);
    bus.cpu_re = 1'b0;
    rst = 1'b0;
    tick();

    // Fill with device stalled, then release it.
    for (int i = 0; i < 5; i++) exp_q.push_back({30'(32'h100 + i), 32'h1000_0000 + 32'(i), 4'hF});
    for (int i = 0; i < 4; i++) begin
      bus.cpu_we = 1'b1; bus.cpu_addr = 30'(32'h100 + i); bus.cpu_wd = 32'h1000_0000 + 32'(i); bus.cpu_be = 4'hF;
      #1;
      check("fill_no_stall", bus.stall, 0);
      tick();
    end
    bus.cpu_addr = 30'h104; bus.cpu_wd = 32'h1000_0004;
    #1;
    check("fill_full", {bus.count, bus.stall, bus.dev_we, bus.dev_addr}, {3'd4, 1'b1, 1'b1, 30'h100});
    tick();
    bus.dev_ready = 1'b1;
    #1;
    check("full_stall_same_cycle_pop", bus.stall, 1);
    tick();
    check("fill_pop1", {bus.dev_addr, bus.count, bus.stall}, {30'h101, 3'd3, 1'b0});
    tick();
    bus.cpu_we = 1'b0;
    check("fill_pop2", {bus.dev_addr, bus.count}, {30'h102, 3'd3});
    tick();
    check("fill_pop3", bus.dev_addr, 30'h103);
    tick();
    check("fill_pop4", {bus.dev_addr, bus.count}, {30'h104, 3'd1});
    drain(0);

    // Wait states: device signals held while dev_ready is low.
    bus.dev_ready = 1'b0;
    do_write(30'h055, 32'hA5A5_A5A5, 4'b0011, 0);
    for (int i = 0; i < 3; i++) begin
      check("ws_hold", {bus.dev_we, bus.dev_addr, bus.dev_wd, bus.dev_be, bus.count},
            {1'b1, 30'h055, 32'hA5A5_A5A5, 4'b0011, 3'd1});
      tick();
    end
    bus.dev_ready = 1'b1;
    #1;
    check("ws_hold_last", {bus.dev_we, bus.dev_addr, bus.dev_wd, bus.dev_be, bus.count},
          {1'b1, 30'h055, 32'hA5A5_A5A5, 4'b0011, 3'd1});
    tick();
    check("ws_retired", {bus.count, bus.dev_we}, 0);

    // Read with empty queue: exactly two stall cycles.
    bus.cpu_re = 1'b1; bus.cpu_addr = 30'h300; bus.dev_rd = 32'h1234_5678;
    #1;
    check("rd_cycle0", {bus.stall, bus.dev_re}, {1'b1, 1'b0});
    tick();
    check("rd_cycle1", {bus.stall, bus.dev_re, bus.dev_addr}, {1'b1, 1'b1, 30'h300});
    tick();
    check("rd_rdone", {bus.stall, bus.dev_re, bus.cpu_rd}, {1'b0, 1'b0, 32'h1234_5678});
    bus.cpu_re = 1'b0;
    tick();

    // Read behind two queued writes.
    do_write(30'h010, 32'h0000_1111, 4'hF, 0);
    do_write(30'h011, 32'h0000_2222, 4'hC, 0);
    bus.cpu_re = 1'b1; bus.cpu_addr = 30'h200; bus.dev_rd = 32'hDEAD_BEEF;
    n = 0;
    #1;
    while (bus.stall && n < 20) begin
      tick(); #1; n++;
    end
    check("rw_stall_cycles", n, 3);
    check("rw_cpu_rd", {bus.cpu_rd, bus.stall}, {32'hDEAD_BEEF, 1'b0});
    bus.cpu_re = 1'b0;
    tick();

    // Simultaneous store and load is a store only.
    re_seen = 1'b0;
    bus.cpu_we = 1'b1; bus.cpu_re = 1'b1; bus.cpu_addr = 30'h3F0; bus.cpu_wd = 32'h0BAD_F00D; bus.cpu_be = 4'h5;
    #1;
    check("we_re_no_stall", bus.stall, 0);
    exp_q.push_back({30'h3F0, 32'h0BAD_F00D, 4'h5});
    tick();
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
    drain(0);
    tick(); tick();
    check("we_re_no_dev_re", re_seen, 0);

    // Wrap-around with a randomly stalling device.
    for (int i = 0; i < 10; i++) do_write(30'(32'h080 + i), $urandom, 4'(i + 1), 1);
    drain(1);
    check("wrap_sb_empty", exp_q.size(), 0);
    check("max_count", max_count <= DEPTH, 1);

    // Asynchronous reset with three stores pending.
    bus.dev_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_write(30'(32'h0C0 + i), 32'hC000_0000 + 32'(i), 4'hF, 0);
    check("pre_reset", {bus.count, bus.dev_we}, {3'd3, 1'b1});
    #2;
    rst = 1'b1;
    bus.cpu_re = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset", {bus.count, bus.dev_we, bus.dev_re, bus.cpu_rd, bus.stall}, 0);
    bus.cpu_re = 1'b0;
    tick(); tick();
    rst = 1'b0;
    bus.dev_ready = 1'b1;
    tick();
    do_write(30'h0AB, 32'h5555_AAAA, 4'h9, 0);
    drain(0);
    tick();
    check("post_reset_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
